// File: rtl/aes_stream_loopback_if.sv
`default_nettype none
// ============================================================================
// Module : aes_stream_loopback_if
// Brief  : valid/ready/data stream bundle used on both sides of the AES engine.
// Rev    : 1.0 - initial release
// ============================================================================
interface aes_stream_loopback_if #(
  parameter int W = 128
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/aes_stream_loopback.sv
`default_nettype none
// ============================================================================
// Module : aes_stream_loopback
// Brief  : streaming AES-128 enc/dec/loopback engine with input FIFO and self-check.
// Rev    : 1.0 - initial release
// ============================================================================
module aes_stream_loopback #(
  parameter int DEPTH    = 4,
  parameter int KEY_WAIT = 12,   // must be >= 10 so all round keys exist on exit
  parameter int CNT_W    = 16
) (
  input  wire                     clk,
  input  wire                     rst,
  input  wire                     kld,
  input  wire [127:0]             key,
  input  wire [1:0]               mode,
  aes_stream_loopback_if.slave    in_if,
  aes_stream_loopback_if.master   out_if,
  output logic                    busy,
  output logic                    mismatch,
  output logic [CNT_W-1:0]        blk_cnt,
  output logic [CNT_W-1:0]        err_cnt
);
  localparam int AW   = $clog2(DEPTH);
  localparam int KW_W = $clog2(KEY_WAIT + 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0, ST_KEY = 3'd1, ST_ISSUE = 3'd2,
    ST_WAIT_ENC = 3'd3, ST_WAIT_DEC = 3'd4, ST_OUT = 3'd5
  } state_t;

  // GF(2^8) arithmetic; S-boxes derived from the field inverse instead of tables
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00; aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = xt(aa);
    end
    return p;
  endfunction
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, sq;
    r = 8'h01; sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction
  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] i;
    i = ginv(a);
    return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
  endfunction
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  // Byte n of the state lives at bits [127-8n -: 8]; n = row + 4*column
  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[r+4*c] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
    for (int c = 0; c < 4; c++) begin
      a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
      if (last) o[127-32*c -: 32] = {a0, a1, a2, a3};
      else o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o ^ k;
  endfunction

  function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [127:0] u, o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        u[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
    u = u ^ k;
    o = u;
    if (!last)
      for (int c = 0; c < 4; c++) begin
        a0 = u[127-32*c -: 8]; a1 = u[119-32*c -: 8];
        a2 = u[111-32*c -: 8]; a3 = u[103-32*c -: 8];
        o[127-32*c -: 32] = {
          gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09),
          gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d),
          gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b),
          gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e)};
      end
    return o;
  endfunction

  function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rcon);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
    w0 = k[127:96] ^ t ^ {rcon, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  state_t          r_state, w_state_nxt;
  logic [127:0]    r_mem [DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [AW:0]     r_count;
  logic [127:0]    r_rk [0:10];
  logic [3:0]      r_kidx;
  logic [7:0]      r_rcon;
  logic [KW_W-1:0] r_kcnt;
  logic            r_key_ok;
  logic [127:0]    r_blk, r_enc_st, r_dec_st, r_out_data;
  logic [1:0]      r_mode;
  logic [3:0]      r_enc_rnd, r_dec_rnd;
  logic            r_enc_busy, r_enc_done, r_dec_busy, r_dec_done, r_out_valid;
  logic            w_push, w_pop, w_kld, w_enc_ld, w_dec_ld, w_hs;
  logic [127:0]    w_head, w_dec_din, w_enc_nxt, w_dec_nxt, w_dec_out;

  assign in_if.ready  = (r_count != (AW+1)'(DEPTH));
  assign w_push       = in_if.valid && in_if.ready;
  assign w_head       = r_mem[r_rptr];
  assign w_hs         = r_out_valid && out_if.ready;
  assign w_enc_nxt    = enc_round(r_enc_st, r_rk[r_enc_rnd], r_enc_rnd == 4'd10);
  assign w_dec_nxt    = dec_round(r_dec_st, r_rk[r_dec_rnd], r_dec_rnd == 4'd0);
  assign w_dec_out    = r_dec_st;
  assign out_if.valid = r_out_valid;
  assign out_if.data  = r_out_data;
  assign busy         = (r_state != ST_IDLE) || (r_count != '0);

  always_comb begin
    w_state_nxt = r_state;
    w_pop = 1'b0; w_kld = 1'b0; w_enc_ld = 1'b0; w_dec_ld = 1'b0;
    w_dec_din = w_head;
    case (r_state)
      ST_IDLE:
        if (kld) begin
          w_kld = 1'b1;
          w_state_nxt = ST_KEY;
        end else if (r_count != '0 && r_key_ok) w_state_nxt = ST_ISSUE;
      ST_KEY:
        if (r_kcnt == KW_W'(KEY_WAIT - 1)) w_state_nxt = ST_IDLE;
      ST_ISSUE: begin
        w_pop = 1'b1;
        if (mode == 2'd1) begin
          w_dec_ld = 1'b1;
          w_state_nxt = ST_WAIT_DEC;
        end else begin
          w_enc_ld = 1'b1;
          w_state_nxt = ST_WAIT_ENC;
        end
      end
      ST_WAIT_ENC:
        if (r_enc_done) begin
          if (r_mode == 2'd0) w_state_nxt = ST_OUT;
          else begin
            w_dec_ld = 1'b1;
            w_dec_din = r_enc_st;
            w_state_nxt = ST_WAIT_DEC;
          end
        end
      ST_WAIT_DEC:
        if (r_dec_done) w_state_nxt = ST_OUT;
      ST_OUT:
        if (w_hs) w_state_nxt = (r_count != '0 && !kld) ? ST_ISSUE : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Storage without reset: FIFO payload and the round-key schedule
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= in_if.data;
    if (w_kld) begin
      r_rk[0] <= key;
      r_kidx  <= 4'd0;
      r_rcon  <= 8'h01;
      r_kcnt  <= '0;
    end else if (r_state == ST_KEY) begin
      r_kcnt <= r_kcnt + 1'b1;
      if (r_kidx != 4'd10) begin
        r_rk[r_kidx + 4'd1] <= key_next(r_rk[r_kidx], r_rcon);
        r_kidx <= r_kidx + 4'd1;
        r_rcon <= xt(r_rcon);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_wptr <= '0; r_rptr <= '0; r_count <= '0;
      r_enc_busy <= 1'b0; r_enc_done <= 1'b0; r_enc_rnd <= '0; r_enc_st <= '0;
      r_dec_busy <= 1'b0; r_dec_done <= 1'b0; r_dec_rnd <= '0; r_dec_st <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;

      r_enc_done <= 1'b0;
      if (w_enc_ld) begin
        r_enc_st <= w_head ^ r_rk[0]; r_enc_rnd <= 4'd1; r_enc_busy <= 1'b1;
      end else if (r_enc_busy) begin
        r_enc_st <= w_enc_nxt;
        if (r_enc_rnd == 4'd10) begin
          r_enc_busy <= 1'b0; r_enc_done <= 1'b1;
        end else r_enc_rnd <= r_enc_rnd + 4'd1;
      end

      r_dec_done <= 1'b0;
      if (w_dec_ld) begin
        r_dec_st <= w_dec_din ^ r_rk[10]; r_dec_rnd <= 4'd9; r_dec_busy <= 1'b1;
      end else if (r_dec_busy) begin
        r_dec_st <= w_dec_nxt;
        if (r_dec_rnd == 4'd0) begin
          r_dec_busy <= 1'b0; r_dec_done <= 1'b1;
        end else r_dec_rnd <= r_dec_rnd - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_ok <= 1'b0; r_blk <= '0; r_mode <= '0;
      r_out_valid <= 1'b0; r_out_data <= '0;
      mismatch <= 1'b0; blk_cnt <= '0; err_cnt <= '0;
    end else begin
      mismatch <= 1'b0;
      if (r_state == ST_KEY && w_state_nxt == ST_IDLE) r_key_ok <= 1'b1;
      if (w_pop) begin
        r_blk  <= w_head;
        r_mode <= mode;
      end
      if (r_state == ST_WAIT_ENC && r_enc_done && r_mode == 2'd0) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_enc_st;
      end
      if (r_state == ST_WAIT_DEC && r_dec_done) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_dec_out;
        if (r_mode == 2'd3 && w_dec_out != r_blk) begin
          mismatch <= 1'b1;
          if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end
      end
      if (r_state == ST_OUT && w_hs) begin
        r_out_valid <= 1'b0;
        blk_cnt     <= blk_cnt + 1'b1;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_aes_stream_loopback.sv
`default_nettype none
// ============================================================================
// Module : tb_aes_stream_loopback
// Brief  : scoreboard bench for aes_stream_loopback using FIPS-197 vectors.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_aes_stream_loopback;
  localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst;
  logic         kld;
  logic [127:0] key;
  logic [1:0]   mode;
  logic         busy, mismatch;
  logic [15:0]  blk_cnt, err_cnt;

  aes_stream_loopback_if #(.W(128)) in_if ();
  aes_stream_loopback_if #(.W(128)) out_if ();

  aes_stream_loopback #(.DEPTH(4), .KEY_WAIT(12), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .kld(kld), .key(key), .mode(mode),
    .in_if(in_if), .out_if(out_if),
    .busy(busy), .mismatch(mismatch), .blk_cnt(blk_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int           tests = 0;
  int           fails = 0;
  int           n_out = 0;
  int           mm_seen = 0;
  logic [127:0] sb [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake
  always @(negedge clk) begin
    if (!rst && out_if.valid && out_if.ready) begin
      n_out++;
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL out_unexpected: got %h expected no output", out_if.data);
      end else begin
        check("out_data", out_if.data, sb.pop_front());
      end
    end
    if (!rst && mismatch) mm_seen++;
  end

  // All tasks begin and end 1 time unit after a rising edge
  task automatic push(input logic [127:0] d, input logic [127:0] exp);
    int g = 0;
    while (!in_if.ready && g < 500) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 500) check("push_timeout", 128'd1, 128'd0);
    in_if.valid = 1'b1;
    in_if.data  = d;
    sb.push_back(exp);
    @(posedge clk); #1;
    in_if.valid = 1'b0;
  endtask

  task automatic load_key(input logic [127:0] k);
    key = k; kld = 1'b1;
    @(posedge clk); #1;
    kld = 1'b0;
    repeat (14) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int c = 0;
    while ((sb.size() != 0 || busy) && c < 1000) begin
      @(posedge clk); #1; c++;
    end
    check(name, 128'(c >= 1000), 128'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] held;
    logic         stable;
    int           c;
    logic [127:0] blocks [5];
    blocks[0] = 128'h0123456789abcdeffedcba9876543210;
    blocks[1] = 128'hdeadbeefcafebabe0011223344556677;
    blocks[2] = 128'hffffffffffffffffffffffffffffffff;
    blocks[3] = 128'h00000000000000000000000000000000;
    blocks[4] = 128'h5a5aa5a55a5aa5a5c3c33c3cc3c33c3c;

    rst = 1'b1; kld = 1'b0; key = '0; mode = 2'd0;
    in_if.valid = 1'b0; in_if.data = '0; out_if.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_out_valid", 128'(out_if.valid), 128'd0);
    check("rst_out_data", out_if.data, 128'd0);
    check("rst_in_ready", 128'(in_if.ready), 128'd1);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_counts", {blk_cnt, err_cnt}, 128'd0);

    // Block queued before any key: held until a key is loaded
    mode = 2'd0;
    push(C_PT, C_CT);
    repeat (30) @(posedge clk);
    #1;
    check("nokey_busy", 128'(busy), 128'd1);
    check("nokey_no_out", 128'(n_out), 128'd0);
    load_key(C_KEY);
    drain("drain_first");
    check("blk_cnt_1", 128'(blk_cnt), 128'd1);

    push(C_PT, C_CT);
    drain("drain_enc");
    check("blk_cnt_2", 128'(blk_cnt), 128'd2);

    mode = 2'd1;
    push(C_CT, C_PT);
    drain("drain_dec");
    check("blk_cnt_3", 128'(blk_cnt), 128'd3);

    mode = 2'd2;
    push(C_PT, C_PT);
    push(C_CT, C_CT);
    drain("drain_loop");
    check("blk_cnt_5", 128'(blk_cnt), 128'd5);

    // Back-to-back loopback+compare: one in flight plus four queued fills the FIFO
    mode = 2'd3;
    for (int i = 0; i < 5; i++) push(blocks[i], blocks[i]);
    check("fifo_full_ready", 128'(in_if.ready), 128'd0);
    drain("drain_cmp");
    check("cmp_no_mismatch", 128'(mm_seen), 128'd0);
    check("cmp_err_cnt", 128'(err_cnt), 128'd0);
    check("blk_cnt_10", 128'(blk_cnt), 128'd10);

    // Back-pressure: output must hold while out_ready is low
    mode = 2'd0;
    out_if.ready = 1'b0;
    push(C_PT, C_CT);
    push(C_PT, C_CT);
    c = 0;
    while (!out_if.valid && c < 300) begin
      @(posedge clk); #1; c++;
    end
    check("hold_valid_seen", 128'(out_if.valid), 128'd1);
    held = out_if.data;
    stable = 1'b1;
    repeat (50) begin
      @(posedge clk); #1;
      if (out_if.valid !== 1'b1 || out_if.data !== held) stable = 1'b0;
    end
    check("hold_stable", 128'(stable), 128'd1);
    check("hold_data", held, C_CT);
    check("hold_blk_cnt", 128'(blk_cnt), 128'd10);
    out_if.ready = 1'b1;
    drain("drain_hold");
    check("blk_cnt_12", 128'(blk_cnt), 128'd12);

    // Reset mid-encryption with two blocks still queued
    push(C_PT, C_CT);
    push(C_PT, C_CT);
    push(C_PT, C_CT);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    check("rst2_out_valid", 128'(out_if.valid), 128'd0);
    check("rst2_fifo_empty", {127'd0, in_if.ready}, 128'd1);
    check("rst2_busy", 128'(busy), 128'd0);
    check("rst2_counts", {blk_cnt, err_cnt}, 128'd0);
    @(posedge clk); #1 rst = 1'b0;
    n_out = 0;

    // Key is gone after reset; then a corrupted compare must be flagged
    mode = 2'd3;
    push(C_PT, 128'd0);
    repeat (30) @(posedge clk);
    #1;
    check("rst2_key_cleared", {126'd0, busy, 1'b0} | 128'(n_out), 128'd2);
    force dut.w_dec_out = 128'd0;
    load_key(C_KEY);
    drain("drain_corrupt");
    release dut.w_dec_out;
    check("corrupt_mismatch", 128'(mm_seen), 128'd1);
    check("corrupt_err_cnt", 128'(err_cnt), 128'd1);
    check("corrupt_blk_cnt", 128'(blk_cnt), 128'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
